camera_txmod: RTL

//  DVP (OV7670-style) camera-interface transmitter/emulator. Generates CMOS_PCLK, CMOS_HREF,

---
 rtl/camera_txmod.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/camera_txmod.sv
// DVP camera transmitter: emits PCLK/HREF/VSYNC/DQ from a fixed-latency pixel source.
// Each 16-bit pixel goes out as two bytes, upper byte first.
module camera_txmod #(
    parameter int H_ACT     = 640,
    parameter int V_ACT     = 480,
    parameter int H_BLANK   = 144,
    parameter int VS_LINES  = 3,
    parameter int V_BACK    = 17,
    parameter int V_FRONT   = 10,
    parameter int PCLK_HALF = 4,
    parameter int PIX_LAT   = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iEn,
    input  logic [15:0] iData,
    output logic        oReq,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oDone,
    output logic        CMOS_PCLK,
    output logic        CMOS_HREF,
    output logic        CMOS_VSYNC,
    output logic [7:0]  CMOS_DQ
);

    localparam int LINE = 2 * H_ACT + H_BLANK;
    localparam int HW   = $clog2(LINE);
    localparam int VM1  = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int VM2  = (V_ACT > V_FRONT) ? V_ACT : V_FRONT;
    localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
    localparam int VW   = $clog2(VMAX + 1);
    localparam int DW   = $clog2(PCLK_HALF);

    localparam logic [HW-1:0] H_LAST   = HW'(LINE - 1);
    localparam logic [HW-1:0] H_ACT2   = HW'(2 * H_ACT);
    localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_e;

    typedef struct packed {
        state_e         st;
        logic [HW-1:0]  h;
        logic [VW-1:0]  v;
    } pos_t;

    function automatic logic [VW-1:0] last_line(input state_e s);
        logic [VW-1:0] r;
        case (s)
            S_VSYNC:  r = VW'(VS_LINES - 1);
            S_VBACK:  r = VW'(V_BACK - 1);
            S_ACTIVE: r = VW'(V_ACT - 1);
            S_VFRONT: r = VW'(V_FRONT - 1);
            default:  r = '0;
        endcase
        return r;
    endfunction

    function automatic state_e after_state(input state_e s, input logic en);
        state_e r;
        case (s)
            S_VSYNC:  r = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
            S_VBACK:  r = S_ACTIVE;
            S_ACTIVE: r = (V_FRONT > 0) ? S_VFRONT : (en ? S_VSYNC : S_IDLE);
            S_VFRONT: r = en ? S_VSYNC : S_IDLE;
            default:  r = S_IDLE;
        endcase
        return r;
    endfunction

    // One PCLK period step of the raster position.
    function automatic pos_t advance(input pos_t p, input logic en);
        pos_t n;
        n = p;
        if (p.st == S_IDLE) begin
            if (en) begin
                n.st = S_VSYNC;
                n.h  = '0;
                n.v  = '0;
            end
        end else if (p.h != H_LAST) begin
            n.h = p.h + 1'b1;
        end else begin
            n.h = '0;
            if (p.v != last_line(p.st)) begin
                n.v = p.v + 1'b1;
            end else begin
                n.v  = '0;
                n.st = after_state(p.st, en);
            end
        end
        return n;
    endfunction

    state_e        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          pclk_q, pclk_d;
    logic          href_q, href_d;
    logic          vsync_q, vsync_d;
    logic [7:0]    dq_q, dq_d;
    logic          done_q, done_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [15:0]   pix_q, pix_d;
    logic [PIX_LAT-1:0] lat_q, lat_d;

    logic tick;
    logic fetch;
    logic req_d;
    pos_t cur, p1, p2;

    always_comb begin
        tick   = (div_q == DIV_LAST) && !pclk_q;
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pclk_d = (div_q == DIV_LAST) ? !pclk_q : pclk_q;

        cur.st = state_q;
        cur.h  = hcnt_q;
        cur.v  = vcnt_q;
        p1     = advance(cur, iEn);
        // Look one more period ahead: a fetch leads its high byte by one tp.
        p2     = advance(p1, iEn);
        fetch  = (p2.st == S_ACTIVE) && !p2.h[0] && (p2.h < H_ACT2);

        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        href_d  = href_q;
        vsync_d = vsync_q;
        dq_d    = dq_q;
        done_d  = 1'b0;
        req_d   = 1'b0;
        x_d     = x_q;
        y_d     = y_q;

        if (tick) begin
            state_d = p1.st;
            hcnt_d  = p1.h;
            vcnt_d  = p1.v;
            vsync_d = (p1.st == S_VSYNC);
            href_d  = (p1.st == S_ACTIVE) && (p1.h < H_ACT2);
            if (href_d) begin
                dq_d = p1.h[0] ? pix_q[7:0] : pix_q[15:8];
            end else begin
                dq_d = '0;
            end
            req_d = fetch;
            if (fetch) begin
                x_d = 10'(p2.h >> 1);
                y_d = 10'(p2.v);
            end
            done_d = (state_q == S_VFRONT ||
                      (state_q == S_ACTIVE && V_FRONT == 0)) &&
                     hcnt_q == H_LAST &&
                     vcnt_q == last_line(state_q);
        end

        lat_d = (lat_q << 1) | PIX_LAT'(req_d);
        pix_d = lat_q[PIX_LAT-1] ? iData : pix_q;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            div_q   <= '0;
            pclk_q  <= 1'b0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            dq_q    <= '0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            div_q   <= div_d;
            pclk_q  <= pclk_d;
            href_q  <= href_d;
            vsync_q <= vsync_d;
            dq_q    <= dq_d;
            done_q  <= done_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
            lat_q   <= lat_d;
        end
    end

    assign oReq       = lat_q[0];
    assign oX         = x_q;
    assign oY         = y_q;
    assign oDone      = done_q;
    assign CMOS_PCLK  = pclk_q;
    assign CMOS_HREF  = href_q;
    assign CMOS_VSYNC = vsync_q;
    assign CMOS_DQ    = dq_q;

endmodule
